// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder: one BLK-bit lookahead group resolved per register stage.
// Optional CLA_SUB_EN macro adds a 'sub' port for a - b.
module pipelined_cla_adder #(
   parameter int N   = 64,
   parameter int BLK = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
`ifdef CLA_SUB_EN
   input  logic         sub,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] sum,
   output logic         cout
);

   localparam int S = N / BLK;

   if ((BLK < 1) || (N % BLK != 0)) begin : g_bad_cfg
      $error("pipelined_cla_adder: N must be a positive multiple of BLK");
   end

   // Valid/ready: a transfer happens on an edge where valid && ready; the whole
   // pipe advances only when the output register is empty or being drained.
   logic         en;
   logic [N-1:0] b_eff;
   logic         c_eff;

   assign en       = !(out_valid && !out_ready);
   assign in_ready = en;

`ifdef CLA_SUB_EN
   // Subtract as a + ~b + 1; the inverted b bits ride down the pipe with a.
   assign b_eff = b ^ {N{sub}};
   assign c_eff = sub | cin;
`else
   assign b_eff = b;
   assign c_eff = cin;
`endif

   // Returns {group carry-out, group sum}.
   function automatic logic [BLK:0] cla_group(input logic [BLK-1:0] x,
                                              input logic [BLK-1:0] y,
                                              input logic           ci);
      logic [BLK-1:0] p;
      logic [BLK-1:0] g;
      logic [BLK:0]   c;
      p    = x ^ y;
      g    = x & y;
      c    = '0;
      c[0] = ci;
      for (int i = 0; i < BLK; i++) begin
         c[i+1] = g[i] | (p[i] & c[i]);
      end
      return {c[BLK], c[BLK-1:0] ^ p};
   endfunction

   for (genvar k = 0; k < S; k++) begin : stage
      logic [BLK-1:0]         ga;
      logic [BLK-1:0]         gb;
      logic                   gci;
      logic                   gv;
      logic [BLK:0]           res;
      logic [(k+1)*BLK-1:0]   s_d;
      logic                   v_q;
      logic                   c_q;
      logic [(k+1)*BLK-1:0]   s_q;

      if (k == 0) begin : src
         assign ga  = a[BLK-1:0];
         assign gb  = b_eff[BLK-1:0];
         assign gci = c_eff;
         assign gv  = in_valid;
         assign s_d = res[BLK-1:0];
      end else begin : src
         assign ga  = stage[k-1].hold.a_q[BLK-1:0];
         assign gb  = stage[k-1].hold.b_q[BLK-1:0];
         assign gci = stage[k-1].c_q;
         assign gv  = stage[k-1].v_q;
         assign s_d = {res[BLK-1:0], stage[k-1].s_q};
      end

      assign res = cla_group(ga, gb, gci);

      // Data only loads with a valid token so bubbles never carry X downstream.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            s_q <= '0;
         end else if (en) begin
            v_q <= gv;
            if (gv) begin
               c_q <= res[BLK];
               s_q <= s_d;
            end
         end
      end

      if (k < S-1) begin : hold
         logic [N-(k+1)*BLK-1:0] a_d;
         logic [N-(k+1)*BLK-1:0] b_d;
         logic [N-(k+1)*BLK-1:0] a_q;
         logic [N-(k+1)*BLK-1:0] b_q;

         if (k == 0) begin : up
            assign a_d = a[N-1:BLK];
            assign b_d = b_eff[N-1:BLK];
         end else begin : up
            assign a_d = stage[k-1].hold.a_q[N-k*BLK-1:BLK];
            assign b_d = stage[k-1].hold.b_q[N-k*BLK-1:BLK];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (en && gv) begin
               a_q <= a_d;
               b_q <= b_d;
            end
         end
      end
   end

   assign out_valid = stage[S-1].v_q;
   assign sum       = stage[S-1].s_q;
   assign cout      = stage[S-1].c_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed testbench for pipelined_cla_adder (N=64, BLK=16, latency 4 stages).
module tb_pipelined_cla_adder;

   localparam int N = 64;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         cin;
`ifdef CLA_SUB_EN
   logic         sub;
`endif
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] sum;
   logic         cout;

   int checks = 0;
   int errors = 0;
   logic [N:0] exp_q[$];

   pipelined_cla_adder #(.N(64), .BLK(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef CLA_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Single transaction into an empty pipe; checks latency and result.
   task automatic run_one(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                          input logic cv, input logic sv,
                          input logic [N-1:0] exp_s, input logic exp_c);
      int n;
      a         = av;
      b         = bv;
      cin       = cv;
`ifdef CLA_SUB_EN
      sub       = sv;
`endif
      out_ready = 1'b1;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      n = 0;
      while (!out_valid && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_lat"}, N'(n), N'(3));
      check({tag, "_sum"}, sum, exp_s);
      check({tag, "_cout"}, N'(cout), N'(exp_c));
      @(posedge clk); #1;
   endtask

   initial begin
      int  sent, rcvd, stall, cyc;
      bit  seen, xin, xout, stale;
      logic [N-1:0] held, exp_s;
      logic [N:0]   e;

      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
`ifdef CLA_SUB_EN
      sub = 1'b0;
`endif
      #12;
      check("rst_out_valid", N'(out_valid), '0);
      check("rst_sum", sum, '0);
      check("rst_cout", N'(cout), '0);
      check("rst_in_ready", N'(in_ready), N'(1));
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_one("basic", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1);
      run_one("multi", 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0,
              64'h1111_1111_1111_1100, 1'b1);
      run_one("blk16", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0);
      run_one("blk48", 64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0001_0000_0000_0000, 1'b0);

      // Backpressure: six back-to-back inputs, 3-cycle stall at first output.
      sent = 0; rcvd = 0; stall = 0; seen = 0; held = '0; cin = 1'b0;
      for (cyc = 0; cyc < 40 && rcvd < 6; cyc++) begin
         if (out_valid && !seen) begin
            seen  = 1;
            stall = 3;
            held  = sum;
         end
         if (stall > 0) begin
            out_ready = 1'b0;
            stall--;
         end else begin
            out_ready = 1'b1;
         end
         in_valid = (sent < 6);
         a = N'(sent + 1);
         b = N'(sent + 1);
         #1;
         if (!out_ready) begin
            check("bp_in_ready_low", N'(in_ready), '0);
            check("bp_sum_stable", sum, held);
         end
         xin  = in_valid && in_ready;
         xout = out_valid && out_ready;
         exp_s = sum;
         e = {cout, sum};
         @(posedge clk); #1;
         if (xin) begin
            exp_q.push_back({1'b0, N'(2 * (sent + 1))});
            sent++;
         end
         if (xout) begin
            if (exp_q.size() == 0) begin
               check("bp_extra_output", exp_s, '0);
            end else begin
               check("bp_result", e[N-1:0], exp_q[0][N-1:0]);
               check("bp_cout", N'(e[N]), N'(exp_q[0][N]));
               void'(exp_q.pop_front());
            end
            rcvd++;
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      check("bp_count", N'(rcvd), N'(6));
      check("bp_queue_empty", N'(exp_q.size()), '0);
      @(posedge clk); #1;

      // Reset mid-operation with three transactions in flight.
      for (int i = 0; i < 3; i++) begin
         a = N'(10 + i); b = N'(1); in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", N'(out_valid), '0);
      check("mid_rst_sum", sum, '0);
      check("mid_rst_cout", N'(cout), '0);
      #4;
      rst_n = 1'b1;
      stale = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (out_valid) stale = 1;
      end
      check("no_stale_after_rst", N'(stale), '0);
      run_one("post_rst", 64'h3, 64'h4, 1'b0, 1'b0, 64'h7, 1'b0);

`ifdef CLA_SUB_EN
      run_one("sub_neg", 64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
      run_one("sub_pos", 64'h7, 64'h5, 1'b0, 1'b1, 64'h2, 1'b1);
      sub = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- N-bit adder built from BLK-bit carry-lookahead groups, with one register stage per group.
- The lowest group is resolved first. Its carry and the not-yet-added upper operand bits move to the next stage.
- Valid/ready handshake on both input and output, with full backpressure.
- Successor to the combinational CLA sum generator. It is the adder datapath for wide-operand units that need high clock rates.

Parameters:
- N, 64, operand/sum width in bits.
- BLK, 16, group width per pipeline stage. N % BLK != 0 is an elaboration error ($error in a generate check).
- S, N/BLK (localparam, not overridable), number of stages = latency in cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  a, b, cin are valid
- in_ready  output  1  block can accept this cycle
- a  input  N  operand A
- b  input  N  operand B
- cin  input  1  carry-in
- out_valid  output  1  sum and cout are valid
- out_ready  input  1  downstream accepts this cycle
- sum  output  N  result
- cout  output  1  carry-out of bit N-1

Behaviour:
- Reset: one clock, asynchronous active-low reset. While rst_n=0:
  - every stage valid bit = 0;
  - out_valid = 0, sum = 0, cout = 0;
  - in_ready = 1 once the stage valid bits are clear.
- Stall/enable:
  - en = !(out_valid && !out_ready); all stage registers load only when en=1.
  - in_ready = en, combinational.
  - Global stall: bubbles do not collapse.
- Transfers:
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
- Stage k (k = 0..S-1), when en=1:
  - Group bits [k*BLK +: BLK].
  - p = a ^ b, g = a & b.
  - Group carries by lookahead: c[0] = carry_in_k, c[i+1] = g[i] | (p[i] & c[i]).
  - Group sum = c ^ p.
  - Registers hold:
    - the valid bit;
    - group carry-out;
    - sum bits [0 : (k+1)*BLK-1];
    - remaining a/b bits above (k+1)*BLK.
  - Stage 0 carry_in = cin.
- Timing: a transaction accepted at edge t is presented on sum/cout/out_valid after edge t+S-1. This gives S cycles of latency when en stays 1.
- Throughput: one result per cycle when out_ready=1.
- Holding: out_valid, sum and cout are register outputs. They stay stable while out_valid=1 and out_ready=0.
- Simultaneous events:
  - Pipeline full and out_ready=1: the output transfer and input transfer happen in the same cycle.
  - in_valid=0 with en=1: a bubble (valid=0) is inserted.
- Bubble data: data on invalid stages is don't-care, but must not be X-propagated to sum when out_valid=0. Data registers are reset to 0.
- BLK = N: S=1, single registered stage, latency 1.
- Width rule: sum = (a + b + cin) mod 2^N, and cout = bit N of the full-width result.
- Reset mid-operation: all in-flight transactions are discarded. No output transfer occurs for them after rst_n rises.

Optional Feature:
- Macro: CLA_SUB_EN.
- Defined:
  - Adds an input port sub (1 bit), sampled with a on input transfer.
  - When sub=1, stage 0 uses b' = ~b and carry_in = 1. cin is ignored.
  - Result: sum = a - b mod 2^N, cout = 1 when no borrow (a >= b unsigned).
  - The inverted b bits travel down the pipeline so that later stages use ~b.
- Not defined: no sub port, and the block is add-only as described above.

Test Plan (N=64, BLK=16, S=4):
- Basic add: a=FFFFFFFFFFFFFFFF, b=0, cin=1, out_ready=1 -> sum=0, cout=1. out_valid rises exactly 4 cycles after the input transfer.
- Multi-group carry: a=123456789ABCDEF0, b=FEDCBA9876543210, cin=0 -> sum=1111111111111100, cout=1.
- Block-boundary carry: a=000000000000FFFF, b=1 -> sum=0000000000010000, cout=0. Repeat with a=0000FFFFFFFFFFFF -> sum=0001000000000000.
- Backpressure: 6 back-to-back inputs (a=i, b=i, i=1..6), with out_ready held 0 for 3 cycles after the first out_valid.
  - in_ready is low during the stall.
  - sum/cout stay stable while stalled.
  - Outputs arrive in order as 2, 4, 6, 8, 10, 12, with none lost or duplicated.
- Reset mid-operation: accept 3 transactions, then pulse rst_n low asynchronously mid-cycle.
  - out_valid, sum and cout go to 0 immediately.
  - No stale result appears after release.
  - The next accepted input (a=3, b=4) produces sum=7.
- CLA_SUB_EN: a=5, b=7, sub=1 -> sum=FFFFFFFFFFFFFFFE, cout=0. Then a=7, b=5, sub=1 -> sum=2, cout=1.
